// File: rtl/hist_fifo_ctrl.sv
// Show-ahead FIFO controller around a 1-cycle-latency dual-port RAM.
// A 2-entry output buffer hides the read latency for 1 word/cycle flow.
module hist_fifo_ctrl #(
  parameter int DATA_W   = 180,
  parameter int ADDR_W   = 6,
  parameter int AFULL_TH = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W+1:0] count,
  output logic              afull
);

  localparam int D  = 1 << ADDR_W;
  localparam int PW = ADDR_W + 1;
  localparam int CW = ADDR_W + 2;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     mem_used, mem_used_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;
  logic [1:0]        ob_left;
  logic [DATA_W-1:0] ob0_q, ob0_d;
  logic [DATA_W-1:0] ob1_q, ob1_d;
  logic              rd_valid_q, rd_valid_d;
  logic              afull_q, afull_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, fetch;
  logic [2:0]        occ, occ_now;

  assign mem_used = wr_ptr_q - rd_ptr_q;
  assign wr_ready = !flush && (mem_used < PW'(D));
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid_q && rd_ready;
  assign occ_now  = {1'b0, ob_cnt_q} + {2'b0, inflight_q};
  assign occ      = occ_now - {2'b0, pop};
  assign fetch    = !flush && (mem_used != '0) && (occ < 3'd2);
  assign ob_left  = ob_cnt_q - {1'b0, pop};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = fetch;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (push)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (fetch)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (pop && ob_cnt_q == 2'd2)
      ob0_d = ob1_q;
    // Returning word lands at the head if the buffer drains this cycle.
    if (inflight_q) begin
      if (ob_left == 2'd0)
        ob0_d = ram_rdata;
      else
        ob1_d = ram_rdata;
    end
    ob_cnt_d = ob_left + {1'b0, inflight_q};
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = '0;
      ob0_d      = ob0_q;
      ob1_d      = ob1_q;
    end
    mem_used_d = wr_ptr_d - rd_ptr_d;
    rd_valid_d = (ob_cnt_d != 2'd0);
    count_d    = CW'(mem_used_d) + CW'(inflight_d)
               + CW'(ob_cnt_d);
    afull_d    = (count_d >= CW'(AFULL_TH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= '0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      afull_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      afull_q    <= afull_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = ob0_q;
  assign count      = count_q;
  assign afull      = afull_q;
  assign ram_we     = push;
  assign ram_addr_a = wr_ptr_q[ADDR_W-1:0];
  assign ram_addr_b = rd_ptr_q[ADDR_W-1:0];
  assign ram_wdata  = wr_data;

  a_occ : assert property (@(posedge clk) disable iff (!rst_n)
    occ_now <= 3'd2);

endmodule

// File: tb/tb_hist_fifo_ctrl.sv
// Directed bench for hist_fifo_ctrl with a behavioural RAM model.
// Vector table for basic flow plus hand sequences for corner cases.
module tb_hist_fifo_ctrl;

  localparam int DW = 180;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW+1:0] count;
  logic          afull;

  int n_chk = 0;
  int n_fail = 0;

  hist_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(56)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a),
    .ram_addr_b(ram_addr_b), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .count(count), .afull(afull)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_wdata;
    ram_rdata <= mem[ram_addr_b];
  end

  typedef struct {
    logic       wv, rr, fl;
    logic [7:0] d;
    logic       ewr, erv;
    logic [7:0] erd, ecnt;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input int d,
                       input logic rr, input logic fl);
    wr_valid = wv;
    wr_data  = DW'(d);
    rd_ready = rr;
    flush    = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int nwr, popped, pushed, gaps;
  bit seen;

  initial begin
    vt[0] = '{1, 0, 0, 8'h01, 1, 0, 8'h00, 8'd1};
    vt[1] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 8'd1};
    vt[2] = '{0, 0, 0, 8'h00, 1, 1, 8'h01, 8'd1};
    vt[3] = '{1, 1, 0, 8'h02, 1, 0, 8'h00, 8'd1};
    vt[4] = '{0, 1, 0, 8'h00, 1, 0, 8'h00, 8'd1};
    vt[5] = '{0, 1, 0, 8'h00, 1, 1, 8'h02, 8'd1};
    vt[6] = '{1, 0, 1, 8'h03, 0, 0, 8'h00, 8'd0};
    vt[7] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 8'd0};

    tick();
    tick();
    chk("rst_rv", DW'(rd_valid), '0);
    chk("rst_cnt", DW'(count), '0);
    chk("rst_af", DW'(afull), '0);
    chk("rst_rd", rd_data, '0);
    chk("rst_we", DW'(ram_we), '0);
    rst_n = 1'b1;

    nwr = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].wv, int'(vt[i].d), vt[i].rr, vt[i].fl);
      #1;
      chk($sformatf("v%0d_wr", i), DW'(wr_ready), DW'(vt[i].ewr));
      chk($sformatf("v%0d_we", i), DW'(ram_we),
          DW'(vt[i].wv & vt[i].ewr));
      if (ram_we)
        chk($sformatf("v%0d_aa", i), DW'(ram_addr_a), DW'(nwr % 64));
      tick();
      if (vt[i].wv && vt[i].ewr) nwr++;
      if (vt[i].fl) nwr = 0;
      chk($sformatf("v%0d_rv", i), DW'(rd_valid), DW'(vt[i].erv));
      chk($sformatf("v%0d_cnt", i), DW'(count), DW'(vt[i].ecnt));
      if (vt[i].erv)
        chk($sformatf("v%0d_rd", i), rd_data, DW'(vt[i].erd));
    end

    // Fill to 66 with consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 66; i++) begin
      drive(1, i, 0, 0);
      #1;
      chk("fill_wr", DW'(wr_ready), 1);
      tick();
    end
    drive(1, 99, 0, 0);
    #1;
    chk("full_wr", DW'(wr_ready), 0);
    chk("full_cnt", DW'(count), 66);
    chk("full_af", DW'(afull), 1);
    popped = 0;
    gaps = 0;
    seen = 0;
    drive(0, 0, 1, 0);
    for (int c = 0; c < 300 && popped < 66; c++) begin
      #1;
      if (rd_valid) begin
        chk("drain_d", rd_data, DW'(popped));
        popped++;
        seen = 1;
      end else if (seen) begin
        gaps++;
      end
      tick();
    end
    chk("drain_n", DW'(popped), 66);
    chk("drain_gap", DW'(gaps), 0);
    chk("drain_cnt", DW'(count), 0);
    chk("drain_rv", DW'(rd_valid), 0);

    // Streaming with 1,1,0 duty on both sides.
    do_reset();
    popped = 0;
    pushed = 0;
    for (int c = 0; c < 2000 && popped < 200; c++) begin
      drive((pushed < 200) && (c % 3 != 2), pushed, c % 3 != 2, 0);
      #1;
      if (rd_valid && rd_ready) begin
        chk("strm_d", rd_data, DW'(popped));
        popped++;
      end
      if (wr_valid && wr_ready) pushed++;
      tick();
      n_chk++;
      if (count > 3) begin
        n_fail++;
        $display("FAIL strm_cnt: got %0d want <=3", count);
      end
    end
    chk("strm_n", DW'(popped), 200);

    // Flush with a simultaneous push.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(1, 100 + i, 0, 0);
      tick();
    end
    chk("f30_cnt", DW'(count), 30);
    drive(1, 8'hAA, 0, 1);
    #1;
    chk("fl_wr", DW'(wr_ready), 0);
    chk("fl_we", DW'(ram_we), 0);
    tick();
    chk("fl_cnt", DW'(count), 0);
    chk("fl_rv", DW'(rd_valid), 0);
    drive(1, 8'h55, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("fl_l1", DW'(rd_valid), 0);
    tick();
    chk("fl_l2", DW'(rd_valid), 0);
    tick();
    chk("fl_l3", DW'(rd_valid), 1);
    chk("fl_d", rd_data, DW'(8'h55));
    chk("fl_c1", DW'(count), 1);

    // Reset asserted while a read is in flight.
    do_reset();
    drive(1, 8'h33, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_rv", DW'(rd_valid), 0);
    chk("mr_cnt", DW'(count), 0);
    chk("mr_rd", rd_data, '0);
    chk("mr_we", DW'(ram_we), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_idle", DW'(rd_valid), 0);
      chk("mr_icnt", DW'(count), 0);
    end
    drive(1, 8'h77, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("mr_l2", DW'(rd_valid), 0);
    tick();
    chk("mr_l3", DW'(rd_valid), 1);
    chk("mr_d", rd_data, DW'(8'h77));

    // Almost-full threshold.
    do_reset();
    for (int i = 0; i < 55; i++) begin
      drive(1, i, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    #1;
    chk("af55", DW'(afull), 0);
    chk("af55_cnt", DW'(count), 55);
    drive(1, 55, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("af56", DW'(afull), 1);
    chk("af56_cnt", DW'(count), 56);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("afpop", DW'(afull), 0);
    chk("afpop_cnt", DW'(count), 55);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
